// File: rtl/relu_pkg.sv
// Shared state encoding and sign/gating helpers for the ReLU forward and backward datapaths.
// Helpers work on a wide container so any datapath width up to RELU_MAX_W can use them.
package relu_pkg;

    localparam int RELU_MAX_W = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FWD   = 2'd1,
        S_BWD   = 2'd2,
        S_DRAIN = 2'd3
    } relu_state_t;

    // x must arrive sign-extended to RELU_MAX_W; derivative at zero is zero
    function automatic logic relu_deriv(input logic [RELU_MAX_W-1:0] x);
        return !x[RELU_MAX_W-1] && (x != '0);
    endfunction

    function automatic logic [RELU_MAX_W-1:0] gate(input logic keep,
                                                   input logic [RELU_MAX_W-1:0] g);
        return keep ? g : '0;
    endfunction

endpackage

// File: rtl/relu_mask_buf.sv
// DEPTH x 1 derivative mask: one synchronous write port, one asynchronous read port.
// Contents are not reset; every entry is rewritten during the forward pass before use.
module relu_mask_buf #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rdata
);

    logic [DEPTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/relu_grad_gate.sv
// Backward ReLU: records one derivative bit per forward activation, then replays the mask
// in order to zero gradients whose activation was not positive.
//
// state   | meaning
// S_IDLE  | waiting for start; nz_count holds last tile's result
// S_FWD   | capturing mask bits from forward activations
// S_BWD   | gating incoming gradients against the replayed mask
// S_DRAIN | last gated gradient waiting for downstream handshake
module relu_grad_gate
    import relu_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   cfg_len,
    input  logic                  fwd_valid,
    input  logic [BIT_WIDTH-1:0]  fwd_data,
    output logic                  fwd_ready,
    input  logic                  bwd_in_valid,
    input  logic [BIT_WIDTH-1:0]  bwd_in_data,
    output logic                  bwd_in_ready,
    output logic                  bwd_out_valid,
    output logic [BIT_WIDTH-1:0]  bwd_out_data,
    input  logic                  bwd_out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   nz_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    relu_state_t           state, state_nxt;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   cfg_len_sat;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  done_zero_q;
    logic                  start_acc, start_zero;
    logic                  fwd_beat, bwd_acc;
    logic                  wr_last, rd_last;
    logic                  drain_exit;
    logic                  mask_wbit, mask_rbit;

    assign cfg_len_sat = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
    assign start_acc   = (state == S_IDLE) && start && (cfg_len != '0);
    assign start_zero  = (state == S_IDLE) && start && (cfg_len == '0);
    assign fwd_beat    = (state == S_FWD) && fwd_valid;
    assign bwd_acc     = bwd_in_valid && bwd_in_ready;
    assign wr_last     = ({1'b0, wr_ptr} == (len_q - 1'b1));
    assign rd_last     = ({1'b0, rd_ptr} == (len_q - 1'b1));
    assign drain_exit  = (state == S_DRAIN) && (!bwd_out_valid || bwd_out_ready);
    assign mask_wbit   = relu_deriv(RELU_MAX_W'(signed'(fwd_data)));

    relu_mask_buf #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mask (
        .clk   (clk),
        .we    (fwd_beat),
        .waddr (wr_ptr),
        .wdata (mask_wbit),
        .raddr (rd_ptr),
        .rdata (mask_rbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        fwd_ready    = 1'b0;
        bwd_in_ready = 1'b0;
        busy         = (state != S_IDLE);
        done         = done_zero_q;
        unique case (state)
            S_IDLE: begin
                if (start_acc) state_nxt = S_FWD;
            end
            S_FWD: begin
                fwd_ready = 1'b1;
                if (fwd_beat && wr_last) state_nxt = S_BWD;
            end
            S_BWD: begin
                bwd_in_ready = !bwd_out_valid || bwd_out_ready;
                if (bwd_in_valid && bwd_in_ready && rd_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_exit) begin
                    state_nxt = S_IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            nz_count    <= '0;
            done_zero_q <= 1'b0;
        end else begin
            done_zero_q <= start_zero;
            if (start_acc) begin
                len_q    <= cfg_len_sat;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                nz_count <= '0;
            end
            if (fwd_beat) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (mask_wbit) nz_count <= nz_count + 1'b1;
            end
            if (bwd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Single output stage: a new beat may load in the same cycle the old one leaves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bwd_out_valid <= 1'b0;
            bwd_out_data  <= '0;
        end else if (bwd_acc) begin
            bwd_out_valid <= 1'b1;
            bwd_out_data  <= BIT_WIDTH'(gate(mask_rbit, RELU_MAX_W'(bwd_in_data)));
        end else if (bwd_out_ready) begin
            bwd_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_grad_gate.sv
// Scoreboard bench for relu_grad_gate: stimulus pushes expected gated gradients,
// a negedge monitor pops and compares on every output handshake.
module tb_relu_grad_gate;

    localparam int BW = 16;
    localparam int DEPTH = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   cfg_len = '0;
    logic          fwd_valid = 1'b0;
    logic [BW-1:0] fwd_data = '0;
    logic          fwd_ready;
    logic          bwd_in_valid = 1'b0;
    logic [BW-1:0] bwd_in_data = '0;
    logic          bwd_in_ready;
    logic          bwd_out_valid;
    logic [BW-1:0] bwd_out_data;
    logic          bwd_out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [AW:0]   nz_count;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    int done_exp = 0;
    logic [BW-1:0] sb[$];

    always #5 clk = ~clk;

    relu_grad_gate #(.BIT_WIDTH(BW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .fwd_valid(fwd_valid), .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .bwd_in_valid(bwd_in_valid), .bwd_in_data(bwd_in_data), .bwd_in_ready(bwd_in_ready),
        .bwd_out_valid(bwd_out_valid), .bwd_out_data(bwd_out_data), .bwd_out_ready(bwd_out_ready),
        .busy(busy), .done(done), .nz_count(nz_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: pops on handshake, checks that a stalled output stays put
    logic          prev_stall = 1'b0;
    logic [BW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_seen++;
            if (prev_stall) begin
                chk("hold_valid", 32'(bwd_out_valid), 32'd1);
                chk("hold_data", 32'(bwd_out_data), 32'(prev_data));
            end
            if (bwd_out_valid && bwd_out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %0h expected none at %0t", bwd_out_data, $time);
                end else begin
                    chk("out_data", 32'(bwd_out_data), 32'(sb.pop_front()));
                end
            end
            prev_stall = bwd_out_valid && !bwd_out_ready;
            prev_data  = bwd_out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int len);
        start = 1'b1;
        cfg_len = (AW+1)'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic send_fwd(input logic [BW-1:0] d);
        bit ok = 1'b0;
        fwd_valid = 1'b1;
        fwd_data = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = fwd_ready;
            tick();
        end
        fwd_valid = 1'b0;
        if (!ok) chk("fwd_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_grad(input logic [BW-1:0] g, input logic [BW-1:0] e);
        bit ok = 1'b0;
        sb.push_back(e);
        bwd_in_valid = 1'b1;
        bwd_in_data = g;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bwd_in_ready;
            tick();
        end
        bwd_in_valid = 1'b0;
        if (!ok) chk("bwd_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int exp_nz);
        bit ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = done;
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
        done_exp++;
        tick();
        chk("done_width", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("nz_count", 32'(nz_count), 32'(exp_nz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(bwd_out_valid), 32'd0);
        chk("rst_nz", 32'(nz_count), 32'd0);
        chk("rst_fwd_ready", 32'(fwd_ready), 32'd0);
        rst = 1'b1;
        tick();

        // basic tile
        start_tile(4);
        chk("fwd_ready_fwd", 32'(fwd_ready), 32'd1);
        send_fwd(16'd5); send_fwd(16'hFFFD); send_fwd(16'd0); send_fwd(16'h7FFF);
        send_grad(16'd10, 16'd10); send_grad(16'd20, 16'd0);
        send_grad(16'd30, 16'd0);  send_grad(16'd40, 16'd40);
        wait_done(2);

        // back-to-back: start the cycle after done; mask[0] was 1 in the previous tile
        start_tile(2);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_nz_clear", 32'(nz_count), 32'd0);
        send_fwd(16'hFFFF); send_fwd(16'd7);
        send_grad(16'd3, 16'd0); send_grad(16'd4, 16'd4);
        wait_done(1);

        // backpressure on the second output beat
        start_tile(4);
        send_fwd(16'd5); send_fwd(16'hFFFD); send_fwd(16'd0); send_fwd(16'h7FFF);
        send_grad(16'd10, 16'd10); send_grad(16'd20, 16'd0);
        bwd_out_ready = 1'b0;
        bwd_in_valid = 1'b1;
        bwd_in_data = 16'd30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bwd_in_ready), 32'd0);
            chk("bp_out_data", 32'(bwd_out_data), 32'd0);
            tick();
        end
        bwd_out_ready = 1'b1;
        send_grad(16'd30, 16'd0); send_grad(16'd40, 16'd40);
        wait_done(2);

        // zero length
        start_tile(0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        done_exp++;
        tick();
        chk("zero_done_width", 32'(done), 32'd0);
        chk("zero_busy2", 32'(busy), 32'd0);

        // start during S_FWD must not re-sample length
        start_tile(4);
        send_fwd(16'h0100);
        start_tile(2);
        send_fwd(16'h8001); send_fwd(16'h0001); send_fwd(16'h7FFF);
        send_grad(16'd11, 16'd11); send_grad(16'd22, 16'd0);
        send_grad(16'd33, 16'd33); send_grad(16'd44, 16'd44);
        wait_done(3);

        // fwd_valid during S_BWD must not write
        start_tile(4);
        for (int i = 0; i < 4; i++) send_fwd(16'hFFFF);
        fwd_valid = 1'b1;
        fwd_data = 16'd1;
        for (int i = 0; i < 4; i++) send_grad(16'(i + 1), 16'd0);
        fwd_valid = 1'b0;
        wait_done(0);

        // full depth, alternating positive / most-negative
        start_tile(256);
        for (int i = 0; i < 256; i++) send_fwd((i % 2 == 0) ? 16'd1 : 16'h8000);
        for (int i = 0; i < 256; i++) send_grad(16'(i), (i % 2 == 0) ? 16'(i) : 16'd0);
        wait_done(128);

        // reset mid-S_BWD with a stalled output
        start_tile(4);
        for (int i = 0; i < 4; i++) send_fwd(16'd9);
        bwd_out_ready = 1'b0;
        send_grad(16'h55, 16'h55);
        @(negedge clk);
        chk("pre_rst_valid", 32'(bwd_out_valid), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bwd_out_valid), 32'd0);
        chk("arst_data", 32'(bwd_out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_in_ready", 32'(bwd_in_ready), 32'd0);
        chk("arst_nz", 32'(nz_count), 32'd0);
        sb.delete();
        tick(); tick();
        rst = 1'b1;
        bwd_out_ready = 1'b1;
        tick();

        // recovery after abort
        start_tile(1);
        send_fwd(16'd2);
        send_grad(16'd9, 16'd9);
        wait_done(1);

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("done_count", 32'(done_seen), 32'(done_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/relu_grad_gate.md
Name: relu_grad_gate

Overview:
- Backward-direction companion of the forward ReLU.
- During the forward pass, captures one derivative bit per activation into a local mask buffer.
- During the backward pass, replays the mask in the same order and gates the incoming gradient stream: passes the gradient where the activation was positive, emits 0 elsewhere.
- Sits beside the forward ReLU in the datapath; the layer controller sequences it per tile.

Parameters:
- BIT_WIDTH, 16, datapath width of activations and gradients (two's complement).
- DEPTH, 256, maximum mask entries per tile.
- ADDR_WIDTH, $clog2(DEPTH), mask index width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a tile; honoured only in S_IDLE
- cfg_len  input  ADDR_WIDTH+1  tile length, 0..DEPTH; sampled on accepted start
- fwd_valid  input  1  forward activation valid (pre-ReLU value)
- fwd_data  input  BIT_WIDTH  forward activation
- fwd_ready  output  1  high in S_FWD
- bwd_in_valid  input  1  gradient valid
- bwd_in_data  input  BIT_WIDTH  gradient
- bwd_in_ready  output  1  gradient accepted when valid&ready
- bwd_out_valid  output  1  gated gradient valid
- bwd_out_data  output  BIT_WIDTH  gated gradient
- bwd_out_ready  input  1  downstream ready
- busy  output  1  state != S_IDLE
- done  output  1  one-cycle pulse at tile completion
- nz_count  output  ADDR_WIDTH+1  number of mask bits set in current/last tile

Behaviour:
- Reset (rst low, async):
  - state=S_IDLE; pointers=0; fwd_ready=0; bwd_in_ready=0; bwd_out_valid=0; bwd_out_data=0; busy=0; done=0; nz_count=0.
  - Mask contents are don't-care.
- FSM states S_IDLE, S_FWD, S_BWD, S_DRAIN.
- S_IDLE:
  - start with cfg_len>0: latch len, clear wr_ptr, rd_ptr and nz_count, go to S_FWD.
  - start with cfg_len=0: stay in S_IDLE, pulse done next cycle.
- S_FWD:
  - fwd_ready=1. Each fwd_valid beat writes mask[wr_ptr] = (fwd_data > 0), i.e. sign=0 and value nonzero. Derivative at 0 is 0.
  - nz_count increments when the written bit is 1; wr_ptr++.
  - The beat with wr_ptr==len-1 moves to S_BWD on the next cycle.
- S_BWD:
  - bwd_in_ready = !bwd_out_valid || bwd_out_ready (single output register, full throughput).
  - Accepted beat: bwd_out_data <= mask[rd_ptr] ? bwd_in_data : 0; bwd_out_valid<=1; rd_ptr++. Latency 1 cycle.
  - The beat with rd_ptr==len-1 moves to S_DRAIN.
- S_DRAIN:
  - bwd_in_ready=0. When the output handshake completes (or bwd_out_valid already 0), go to S_IDLE and pulse done in that same transition cycle.
- Output register:
  - Holds data and valid stable while bwd_out_valid & !bwd_out_ready.
  - Clears valid on handshake with no new beat.
- Ignored inputs:
  - start while busy is ignored; cfg_len is not re-sampled.
  - fwd_valid outside S_FWD is ignored; no write.
  - bwd_in_valid outside S_BWD is not accepted (ready=0).
- nz_count holds its value in S_IDLE until the next accepted start.
- cfg_len > DEPTH is illegal; the design saturates len to DEPTH.
- Reset mid-tile aborts immediately to S_IDLE with no done pulse.

Decomposition:
- Shared package (relu_pkg):
  - state enum: S_IDLE, S_FWD, S_BWD, S_DRAIN.
  - relu_deriv function: returns 1 when x is positive.
  - gate function: returns g or 0.
  - the forward ReLU can reuse the sign-test helper.
- One natural sub-module: relu_mask_buf, a DEPTH x 1 flop array with one write port and one async read port.
- FSM, pointers and output register stay in the top module.

Test Plan:
- Reset: assert rst low mid-S_BWD with bwd_out_valid=1 -> all outputs 0 and state S_IDLE immediately; no done pulse.
- Basic tile: len=4; fwd = 5, -3, 0, 0x7FFF; bwd grads 10, 20, 30, 40 with out_ready=1.
  - Required: outputs 10, 0, 0, 40 on consecutive cycles, each 1 cycle after accept.
  - nz_count=2; done pulses once after the 4th output handshake.
- Backpressure: same tile with out_ready low for 3 cycles on beat 2.
  - Required: bwd_out_data holds 0 stable; bwd_in_ready=0; no beat lost or duplicated.
- Full depth: len=256, fwd alternating 1 / 0x8000, grads = index.
  - Required: even indices pass, odd indices give 0; nz_count=128; pointer wrap correct at 255.
- Boundary and ignored inputs: len=0 -> done pulse, busy stays 0; start during S_FWD ignored; fwd_valid in S_BWD writes nothing (verify by replaying the mask).
- Back-to-back tiles: start asserted the cycle after done with len=2 -> new tile accepted; nz_count cleared; old mask not leaked.
